uart_rx_axis: RTL and testbench
===============================

UART_RX_AXIS -- requirements
Module: uart_rx_axis

Interface
REQ-001 SHALL provide parameter DATA_WIDTH, default 8, number of data bits per frame.
REQ-002 SHALL provide port clk, input, 1, the single clock for all logic.
REQ-003 SHALL provide port rst, input, 1, synchronous active-high reset.
REQ-004 SHALL provide port m_axis_tdata, output, DATA_WIDTH, received byte.
REQ-005 SHALL provide port m_axis_tvalid, output, 1, received byte available.
REQ-006 SHALL provide port m_axis_tready, input, 1, consumer accepts the byte.
REQ-007 SHALL provide port rxd, input, 1, asynchronous serial line, idle high.
REQ-008 SHALL provide port busy, output, 1, frame reception in progress.
REQ-009 SHALL provide port overrun_error, output, 1, one-cycle pulse when an unconsumed byte is overwritten.
REQ-010 SHALL provide port frame_error, output, 1, one-cycle pulse when the stop bit samples low.
REQ-011 SHALL provide port prescale, input, 16, clock cycles per 1/8 bit; bit period = prescale*8 cycles; the value is sampled at start-bit detection.

Function
REQ-012 SHALL pass rxd through a two-flop synchronizer reset to 1; all decisions use the synchronized value rxd_s.
REQ-013 SHALL implement states IDLE, START, DATA, STOP, WAIT_HIGH.
REQ-014 IDLE: rxd_s==0 -> START; load bit counter with prescale*4-1 (half bit); busy=0 only in IDLE.
REQ-015 START: at counter expiry, rxd_s==0 -> DATA with counter prescale*8-1; rxd_s==1 -> IDLE (false start, no output, no error).
REQ-016 DATA: sample rxd_s at each counter expiry, shift in LSB first, reload prescale*8-1; after DATA_WIDTH samples -> STOP.
REQ-017 STOP: at counter expiry, rxd_s==1 -> load m_axis_tdata, set m_axis_tvalid on the next edge, -> IDLE.
REQ-018 STOP with rxd_s==0 -> pulse frame_error, discard the byte, leave m_axis_tvalid/tdata unchanged, -> WAIT_HIGH.
REQ-019 WAIT_HIGH: remain until rxd_s==1, then -> IDLE; this prevents a break condition from being decoded as frames.
REQ-020 m_axis_tvalid SHALL clear on the edge where m_axis_tvalid && m_axis_tready; tdata SHALL stay stable while tvalid=1 and not accepted.
REQ-021 Good stop while m_axis_tvalid=1 and m_axis_tready=0 SHALL overwrite tdata, keep tvalid=1, and pulse overrun_error.
REQ-022 Good stop coinciding with a handshake on the same edge SHALL load new data, keep tvalid=1, and not flag an overrun.
REQ-023 m_axis_tready SHALL never influence reception timing; the RX does not stall.
REQ-024 Counters SHALL be 19 bits wide; prescale==0 SHALL be treated as 1.
REQ-025 Byte-to-tvalid latency SHALL be one cycle after the stop-bit sample edge.

Reset
REQ-026 While rst=1: state=IDLE, counters=0, m_axis_tdata=0, m_axis_tvalid=0, busy=0, overrun_error=0, frame_error=0, synchronizer flops=1.
REQ-027 rst asserted mid-frame SHALL abandon the frame with no output and no error pulse; reception restarts at the next falling edge after release.

Verification (prescale=6, bit period 48 cycles)
REQ-028 Frame 0x55 with a good stop and tready=1 -> one tvalid cycle with tdata=0x55, no error pulses.
REQ-029 Frames 0x11 then 0x22 back-to-back with tready=0 until both are done -> tdata=0x22, tvalid=1, exactly one overrun_error pulse.
REQ-030 Low glitch of 10 cycles on rxd -> back to IDLE, no tvalid, no error, busy returns to 0.
REQ-031 Frame 0xA5 with stop bit held low for 200 cycles -> one frame_error pulse, no tvalid, no new frame until rxd returns high.
REQ-032 rst pulse at data bit 3 of 0x3C, then a clean 0x3C frame -> exactly one tvalid with tdata=0x3C.
REQ-033 Loopback from the UART TX stage: bytes 0x11, 0x22 via s_axis -> txd -> rxd -> exactly two m_axis bytes, in order, matching.

Source files
------------

// File: rtl/uart_rx_axis.sv
// 8x-oversampling-free UART receiver: samples each bit at its midpoint using a
// prescale-derived counter and presents received bytes on an AXI-Stream master.
module uart_rx_axis #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    input  logic                  rxd,
    output logic                  busy,
    output logic                  overrun_error,
    output logic                  frame_error,
    input  logic [15:0]           prescale
);

    localparam int BW = $clog2(DATA_WIDTH);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

    state_t                  state_q;
    logic                    rxd_m_q;
    logic                    rxd_s_q;
    logic [18:0]             cnt_q;
    logic [18:0]             reload_q;
    logic [BW-1:0]           bit_q;
    logic [DATA_WIDTH-1:0]   shift_q;
    logic [DATA_WIDTH-1:0]   tdata_q;
    logic                    tvalid_q;
    logic                    busy_q;
    logic                    oe_q;
    logic                    fe_q;

    logic [15:0]             presc_d;
    logic [18:0]             half_d;
    logic [18:0]             full_d;
    logic                    expire_d;
    logic                    handshake_d;

    // A zero prescale would make the half-bit reload underflow, so clamp to 1.
    assign presc_d     = (prescale == 16'd0) ? 16'd1 : prescale;
    assign half_d      = {1'b0, presc_d, 2'b00} - 19'd1;
    assign full_d      = {presc_d, 3'b000} - 19'd1;
    assign expire_d    = (cnt_q == 19'd0);
    assign handshake_d = tvalid_q && m_axis_tready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            rxd_m_q  <= 1'b1;
            rxd_s_q  <= 1'b1;
            cnt_q    <= '0;
            reload_q <= '0;
            bit_q    <= '0;
            tdata_q  <= '0;
            tvalid_q <= 1'b0;
            busy_q   <= 1'b0;
            oe_q     <= 1'b0;
            fe_q     <= 1'b0;
        end else begin
            rxd_m_q <= rxd;
            rxd_s_q <= rxd_m_q;
            oe_q    <= 1'b0;
            fe_q    <= 1'b0;
            if (handshake_d) begin
                tvalid_q <= 1'b0;
            end
            case (state_q)
                IDLE: begin
                    if (!rxd_s_q) begin
                        state_q  <= START;
                        cnt_q    <= half_d;
                        reload_q <= full_d;
                        bit_q    <= '0;
                        busy_q   <= 1'b1;
                    end
                end
                START: begin
                    if (expire_d) begin
                        if (!rxd_s_q) begin
                            state_q <= DATA;
                            cnt_q   <= reload_q;
                        end else begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_q - 19'd1;
                    end
                end
                DATA: begin
                    if (expire_d) begin
                        cnt_q <= reload_q;
                        bit_q <= bit_q + BW'(1);
                        if (bit_q == LAST_BIT) begin
                            state_q <= STOP;
                        end
                    end else begin
                        cnt_q <= cnt_q - 19'd1;
                    end
                end
                STOP: begin
                    if (expire_d) begin
                        if (rxd_s_q) begin
                            // Loading over a still-pending byte is an overrun unless it is being taken this edge.
                            state_q  <= IDLE;
                            busy_q   <= 1'b0;
                            tdata_q  <= shift_q;
                            tvalid_q <= 1'b1;
                            oe_q     <= tvalid_q && !m_axis_tready;
                        end else begin
                            state_q <= WAIT_HIGH;
                            fe_q    <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q - 19'd1;
                    end
                end
                WAIT_HIGH: begin
                    if (rxd_s_q) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Data shift register needs no reset; it is only observed after a full frame.
    always_ff @(posedge clk) begin
        if (state_q == DATA && expire_d) begin
            shift_q <= {rxd_s_q, shift_q[DATA_WIDTH-1:1]};
        end
    end

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign busy          = busy_q;
    assign overrun_error = oe_q;
    assign frame_error   = fe_q;

endmodule

// File: tb/tb_uart_rx_axis.sv
// Directed bench for uart_rx_axis at prescale=6 (48-cycle bits), with a
// scoreboard queue of expected bytes and a small behavioural UART TX for loopback.
module tb_uart_rx_axis;

    localparam int BIT = 48;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b1;
    logic        busy;
    logic        overrun_error;
    logic        frame_error;
    logic [15:0] prescale = 16'd6;
    logic        rxd;
    logic        rxd_drv = 1'b1;
    logic        txd = 1'b1;
    logic        loop_en = 1'b0;

    logic        s_valid = 1'b0;
    logic        s_ready = 1'b0;
    logic [7:0]  s_data = 8'h00;
    logic [9:0]  tx_sh = 10'h3ff;
    int          tx_left = 0;
    int          tx_cnt = 0;

    int checks = 0;
    int errors = 0;
    int acc_cnt = 0;
    int tv_cycles = 0;
    int oe_cnt = 0;
    int fe_cnt = 0;
    logic [7:0] exp_q[$];

    assign rxd = loop_en ? txd : rxd_drv;

    always #5 clk = ~clk;

    uart_rx_axis #(.DATA_WIDTH(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .rxd           (rxd),
        .busy          (busy),
        .overrun_error (overrun_error),
        .frame_error   (frame_error),
        .prescale      (prescale)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Behavioural 8N1 transmitter fed by a simple valid/ready byte port.
    always @(posedge clk) begin
        s_ready <= 1'b0;
        if (tx_cnt != 0) begin
            tx_cnt <= tx_cnt - 1;
        end else if (tx_left != 0) begin
            txd     <= tx_sh[0];
            tx_sh   <= tx_sh >> 1;
            tx_left <= tx_left - 1;
            tx_cnt  <= BIT - 1;
        end else if (s_valid) begin
            tx_sh   <= {1'b1, s_data, 1'b0};
            tx_left <= 10;
            s_ready <= 1'b1;
        end
    end

    // Output monitor: every accepted beat is compared against the scoreboard head.
    always @(negedge clk) begin
        if (m_axis_tvalid === 1'b1) tv_cycles++;
        if (overrun_error === 1'b1) oe_cnt++;
        if (frame_error === 1'b1) fe_cnt++;
        if (m_axis_tvalid === 1'b1 && m_axis_tready === 1'b1) begin
            acc_cnt++;
            if (exp_q.size() == 0) check("unexpected_byte", 32'(m_axis_tdata) | 32'h100, 32'(m_axis_tdata));
            else check("tdata", 32'(m_axis_tdata), 32'(exp_q.pop_front()));
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic b, input int n);
        rxd_drv = b;
        wait_cycles(n);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_lvl, input int stop_len);
        drive_bit(1'b0, BIT);
        for (int i = 0; i < 8; i++) drive_bit(d[i], BIT);
        drive_bit(stop_lvl, stop_len);
    endtask

    task automatic axis_send(input logic [7:0] b);
        s_data  = b;
        s_valid = 1'b1;
        for (int i = 0; i < 2000 && !s_ready; i++) wait_cycles(1);
        check("tx_accept", 32'(s_ready), 32'd1);
        s_valid = 1'b0;
        wait_cycles(1);
    endtask

    int a0, tv0, oe0, fe0;

    initial begin
        wait_cycles(4);
        check("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
        check("rst_tdata", 32'(m_axis_tdata), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_oe", 32'(overrun_error), 32'd0);
        check("rst_fe", 32'(frame_error), 32'd0);
        rst = 1'b0;
        wait_cycles(BIT);

        // Single good frame, consumer always ready
        a0 = acc_cnt; tv0 = tv_cycles; oe0 = oe_cnt; fe0 = fe_cnt;
        exp_q.push_back(8'h55);
        send_frame(8'h55, 1'b1, BIT);
        wait_cycles(2 * BIT);
        check("t1_accepted", acc_cnt - a0, 1);
        check("t1_tvalid_cycles", tv_cycles - tv0, 1);
        check("t1_errors", (oe_cnt - oe0) + (fe_cnt - fe0), 0);
        check("t1_busy_idle", 32'(busy), 32'd0);

        // Two frames with consumer stalled: second overwrites first
        m_axis_tready = 1'b0;
        oe0 = oe_cnt; fe0 = fe_cnt;
        exp_q.push_back(8'h22);
        send_frame(8'h11, 1'b1, BIT);
        send_frame(8'h22, 1'b1, BIT);
        wait_cycles(10);
        check("t2_tdata", 32'(m_axis_tdata), 32'h22);
        check("t2_tvalid", 32'(m_axis_tvalid), 32'd1);
        check("t2_overrun_pulses", oe_cnt - oe0, 1);
        check("t2_frame_err", fe_cnt - fe0, 0);
        a0 = acc_cnt;
        m_axis_tready = 1'b1;
        wait_cycles(3);
        check("t2_drained", acc_cnt - a0, 1);
        check("t2_tvalid_clear", 32'(m_axis_tvalid), 32'd0);
        check("t2_queue_empty", exp_q.size(), 0);

        // Short low glitch: false start
        tv0 = tv_cycles; oe0 = oe_cnt; fe0 = fe_cnt;
        drive_bit(1'b0, 10);
        check("t3_busy_during", 32'(busy), 32'd1);
        drive_bit(1'b1, 2 * BIT);
        check("t3_busy_after", 32'(busy), 32'd0);
        check("t3_no_tvalid", tv_cycles - tv0, 0);
        check("t3_no_errors", (oe_cnt - oe0) + (fe_cnt - fe0), 0);

        // Stop bit held low (break): one frame error, line must return high
        a0 = acc_cnt; tv0 = tv_cycles; oe0 = oe_cnt; fe0 = fe_cnt;
        send_frame(8'hA5, 1'b0, 200);
        check("t4_fe_pulses", fe_cnt - fe0, 1);
        check("t4_busy_wait_high", 32'(busy), 32'd1);
        check("t4_tvalid", 32'(m_axis_tvalid), 32'd0);
        drive_bit(1'b1, 2 * BIT);
        check("t4_busy_after", 32'(busy), 32'd0);
        check("t4_no_tvalid", tv_cycles - tv0, 0);
        check("t4_fe_total", fe_cnt - fe0, 1);
        check("t4_no_overrun", oe_cnt - oe0, 0);

        // Reset mid-frame, then a clean frame
        a0 = acc_cnt; oe0 = oe_cnt; fe0 = fe_cnt;
        drive_bit(1'b0, BIT);
        drive_bit(1'b0, BIT);
        drive_bit(1'b0, BIT);
        drive_bit(1'b1, BIT);
        rxd_drv = 1'b1;
        wait_cycles(24);
        rst = 1'b1;
        wait_cycles(2);
        check("t5_busy_in_rst", 32'(busy), 32'd0);
        check("t5_tvalid_in_rst", 32'(m_axis_tvalid), 32'd0);
        rst = 1'b0;
        drive_bit(1'b1, 3 * BIT);
        check("t5_abandoned", acc_cnt - a0, 0);
        exp_q.push_back(8'h3C);
        send_frame(8'h3C, 1'b1, BIT);
        wait_cycles(2 * BIT);
        check("t5_one_byte", acc_cnt - a0, 1);
        check("t5_no_errors", (oe_cnt - oe0) + (fe_cnt - fe0), 0);

        // Loopback through the behavioural transmitter
        loop_en = 1'b1;
        a0 = acc_cnt; oe0 = oe_cnt; fe0 = fe_cnt;
        exp_q.push_back(8'h11);
        axis_send(8'h11);
        exp_q.push_back(8'h22);
        axis_send(8'h22);
        for (int i = 0; i < 3000 && (acc_cnt - a0) < 2; i++) wait_cycles(1);
        wait_cycles(BIT);
        check("t6_bytes", acc_cnt - a0, 2);
        check("t6_queue_empty", exp_q.size(), 0);
        check("t6_no_errors", (oe_cnt - oe0) + (fe_cnt - fe0), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
